// File: rtl/note_pkg.sv
// Shared note codes, widths and FSM state type for the note scheduler.
// encodeNote turns the fret switches into a note code (only exact one-hot selections are valid).
package note_pkg;

  localparam int NOTE_W = 3;

  localparam logic [NOTE_W-1:0] NOTE_A = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_B = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_C = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_D = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_E = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_F = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_G = 3'd6;

  localparam logic [NOTE_W-1:0] DEFAULT_NOTE = NOTE_G;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Anything other than exactly one closed fret falls back to G.
  function automatic logic [NOTE_W-1:0] encodeNote(input logic [6:0] sw);
    logic [NOTE_W-1:0] code;
    code = DEFAULT_NOTE;
    if ($onehot(sw)) begin
      for (int i = 0; i < 7; i++) begin
        if (sw[i]) code = NOTE_W'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/note_queue.sv
// Small synchronous FIFO holding pending strum note codes.
// The head entry is visible on popData while empty is low, so a pop consumes it in the same cycle.
module note_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          pushOk;
  logic          popOk;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign popOk   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
  assign pushOk  = push && (!full || popOk);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      case ({pushOk, popOk})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Turns strum edges into timed notes: fixed sustain with gate high, then a fixed silent gap.
// Define STRUM_QUEUE_EN to queue strums in order; otherwise each strum preempts the current note.
module note_scheduler
  import note_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int SUSTAIN_MS  = 500,
  parameter int GAP_CYCLES  = 1024,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strumEdge,
  input  logic [6:0]        switches,
  output logic [NOTE_W-1:0] noteSel,
  output logic              noteGate,
  output logic              noteStart,
  output logic              busy,
  output logic              queueFull,
  output logic [7:0]        dropCount
);

  localparam int SUSTAIN_CYCLES = CLK_HZ / 1000 * SUSTAIN_MS;
  localparam int SUS_W          = $clog2(SUSTAIN_CYCLES);
  localparam int GAP_W          = $clog2(GAP_CYCLES + 1);

  if (SUSTAIN_CYCLES < 2) begin : g_badSustain
    $error("note_scheduler: sustain must be at least 2 cycles");
  end
  if (GAP_CYCLES < 1) begin : g_badGap
    $error("note_scheduler: gap must be at least 1 cycle");
  end
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_badDepth
    $error("note_scheduler: queue depth must be a power of two >= 2");
  end

  state_t             state;
  logic [SUS_W-1:0]   susCnt;
  logic [GAP_W-1:0]   gapCnt;
  logic               strumPend;
  logic [NOTE_W-1:0]  strumCode;
  logic               haveNote;
  logic [NOTE_W-1:0]  nextCode;
  logic               loadNow;

  // Capture stage: the switches are encoded on the strum edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      strumPend <= 1'b0;
      strumCode <= DEFAULT_NOTE;
    end else begin
      strumPend <= strumEdge;
      strumCode <= encodeNote(switches);
    end
  end

`ifdef STRUM_QUEUE_EN
  logic              qFull;
  logic              qEmpty;
  logic [NOTE_W-1:0] qHead;

  note_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (NOTE_W)
  ) uQueue (
    .clk      (clk),
    .reset    (reset),
    .push     (strumPend),
    .pushData (strumCode),
    .pop      (loadNow),
    .popData  (qHead),
    .full     (qFull),
    .empty    (qEmpty)
  );

  assign haveNote  = !qEmpty;
  assign nextCode  = qHead;
  assign queueFull = qFull;
  // Queued notes never cut a note short; they wait for IDLE or the last gap cycle.
  assign loadNow   = haveNote && ((state == IDLE) || ((state == GAP) && (gapCnt == '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      dropCount <= 8'd0;
    end else if (strumPend && qFull && !loadNow && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end
`else
  assign haveNote  = strumPend;
  assign nextCode  = strumCode;
  assign loadNow   = haveNote;
  assign queueFull = 1'b0;
  assign dropCount = 8'd0;
`endif

  // Sustain runs SUSTAIN_CYCLES-1 down to 0 in PLAY, gap runs GAP_CYCLES-1 down to 0 in GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      noteSel   <= '0;
      noteGate  <= 1'b0;
      noteStart <= 1'b0;
      busy      <= 1'b0;
      susCnt    <= '0;
      gapCnt    <= '0;
    end else begin
      noteStart <= 1'b0;
      if (loadNow) begin
        state     <= PLAY;
        noteSel   <= nextCode;
        noteStart <= 1'b1;
        noteGate  <= 1'b1;
        busy      <= 1'b1;
        susCnt    <= SUS_W'(SUSTAIN_CYCLES - 1);
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          PLAY: begin
            if (susCnt == '0) begin
              state    <= GAP;
              noteGate <= 1'b0;
              gapCnt   <= GAP_W'(GAP_CYCLES - 1);
            end else begin
              susCnt <= susCnt - SUS_W'(1);
            end
          end
          GAP: begin
            if (gapCnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gapCnt <= gapCnt - GAP_W'(1);
            end
          end
          default: begin
            state    <= IDLE;
            noteGate <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Randomized self-checking bench for note_scheduler against a timeline model (sustain 8, gap 2, depth 4).
// Queue scenarios are built only when STRUM_QUEUE_EN is defined; preemption only when it is not.
module tb_note_scheduler;

  localparam int CLK_HZ      = 4000;
  localparam int SUSTAIN_MS  = 2;
  localparam int GAP_CYCLES  = 2;
  localparam int QUEUE_DEPTH = 4;
  localparam int S = 8;
  localparam int G = GAP_CYCLES;
  localparam int D = QUEUE_DEPTH;

  logic       clk = 1'b0;
  logic       reset;
  logic       strumEdge;
  logic [6:0] switches;
  logic [2:0] noteSel;
  logic       noteGate;
  logic       noteStart;
  logic       busy;
  logic       queueFull;
  logic [7:0] dropCount;
  logic [14:0] obs;

  int checks   = 0;
  int failures = 0;

  // Model: everything derives from the edge of the most recent load.
  int         cyc       = 0;
  int         lastLoad  = 0;
  bit         hasLoad   = 1'b0;
  logic [2:0] mSel      = 3'd0;
  int         mDrop     = 0;
  int         mq[$];
  bit         mPend     = 1'b0;
  int         mPendCode = 0;

  assign obs = {noteSel, noteGate, noteStart, busy, queueFull, dropCount};

  always #5 clk = ~clk;

  note_scheduler #(
    .CLK_HZ      (CLK_HZ),
    .SUSTAIN_MS  (SUSTAIN_MS),
    .GAP_CYCLES  (GAP_CYCLES),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .strumEdge (strumEdge),
    .switches  (switches),
    .noteSel   (noteSel),
    .noteGate  (noteGate),
    .noteStart (noteStart),
    .busy      (busy),
    .queueFull (queueFull),
    .dropCount (dropCount)
  );

  function automatic int encodeRef(input logic [6:0] sw);
    if ($countones(sw) != 1) return 6;
    for (int i = 0; i < 7; i++) if (sw[i]) return i;
    return 6;
  endfunction

  function automatic logic [6:0] randSw();
    if ($urandom_range(0, 1) == 1) return 7'(1 << $urandom_range(0, 6));
    return 7'($urandom);
  endfunction

  function automatic logic [14:0] expVec();
    int   age;
    logic g, s, b, qf;
    age = cyc - lastLoad;
    g   = hasLoad && (age < S);
    s   = hasLoad && (age == 0);
    b   = hasLoad && (age < S + G);
`ifdef STRUM_QUEUE_EN
    qf  = (mq.size() == D);
`else
    qf  = 1'b0;
`endif
    return {mSel, g, s, b, qf, 8'(mDrop)};
  endfunction

  task automatic modelEdge(input logic rst, input logic strum, input logic [6:0] sw);
    cyc++;
    if (rst) begin
      hasLoad = 1'b0;
      mSel    = 3'd0;
      mDrop   = 0;
      mq.delete();
      mPend   = 1'b0;
    end else begin
`ifdef STRUM_QUEUE_EN
      if (mq.size() > 0 && (!hasLoad || (cyc - lastLoad) >= S + G)) begin
        mSel     = 3'(mq.pop_front());
        lastLoad = cyc;
        hasLoad  = 1'b1;
      end
      if (mPend) begin
        if (mq.size() < D) mq.push_back(mPendCode);
        else if (mDrop < 255) mDrop++;
      end
`else
      if (mPend) begin
        mSel     = 3'(mPendCode);
        lastLoad = cyc;
        hasLoad  = 1'b1;
      end
`endif
      mPend     = strum;
      mPendCode = encodeRef(sw);
    end
  endtask

  task automatic applyStep(input logic rst, input logic strum, input logic [6:0] sw);
    reset     = rst;
    strumEdge = strum;
    switches  = sw;
    @(posedge clk);
    modelEdge(rst, strum, sw);
    #1;
  endtask

  task automatic test_reset();
    applyStep(1'b1, 1'b0, 7'b0);
    applyStep(1'b1, 1'b1, 7'b0000100);
    checks++;
    if (obs !== 15'b0) begin
      failures++; $display("[TB] FAIL reset_state got=%h want=%h", obs, 15'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
    end
    checks++;
    if ({noteGate, busy} !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_strum_ignored got=%b want=00", {noteGate, busy});
    end
  endtask

  task automatic test_single_strum();
    int starts = 0, gateCyc = 0, busyCyc = 0;
    logic [2:0] sel = 3'd7;
    applyStep(1'b0, 1'b1, 7'b0001000);
    checks++;
    if (obs !== expVec()) begin
      failures++; $display("[TB] FAIL single_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
    end
    for (int i = 0; i < 14; i++) begin
      applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL single_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      if (noteStart) begin starts++; sel = noteSel; end
      if (noteGate) gateCyc++;
      if (busy) busyCyc++;
    end
    checks++;
    if (sel !== 3'd3) begin failures++; $display("[TB] FAIL single_sel got=%0d want=3", sel); end
    checks++;
    if (starts != 1) begin failures++; $display("[TB] FAIL single_starts got=%0d want=1", starts); end
    checks++;
    if (gateCyc != S) begin failures++; $display("[TB] FAIL single_gate_len got=%0d want=%0d", gateCyc, S); end
    checks++;
    if (busyCyc != S + G) begin failures++; $display("[TB] FAIL single_busy_len got=%0d want=%0d", busyCyc, S + G); end
  endtask

  task automatic test_invalid_selection();
    logic [6:0] pat;
    logic [2:0] sel;
    int starts;
    for (int p = 0; p < 2; p++) begin
      pat = (p == 0) ? 7'b0000000 : 7'b0110000;
      sel = 3'd7;
      starts = 0;
      applyStep(1'b0, 1'b1, pat);
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL invalid_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      for (int i = 0; i < 14; i++) begin
        applyStep(1'b0, 1'b0, randSw());
        checks++;
        if (obs !== expVec()) begin
          failures++; $display("[TB] FAIL invalid_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
        end
        if (noteStart) begin starts++; sel = noteSel; end
      end
      checks++;
      if (sel !== 3'd6 || starts != 1) begin
        failures++; $display("[TB] FAIL invalid_sel pat=%b got=%0d/%0d want=6/1", pat, sel, starts);
      end
    end
  endtask

  task automatic test_reset_mid_note();
    int gc = 0, gateCyc = 0;
    logic [2:0] sel = 3'd7;
    applyStep(1'b0, 1'b1, 7'b0000100);
    for (int i = 0; i < 10 && gc < 3; i++) begin
      applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL resetmid_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      if (noteGate) gc++;
    end
    checks++;
    if (gc != 3) begin failures++; $display("[TB] FAIL resetmid_reach got=%0d want=3", gc); end
    applyStep(1'b1, 1'b0, randSw());
    checks++;
    if (obs !== 15'b0) begin
      failures++; $display("[TB] FAIL resetmid_outputs got=%h want=%h", obs, 15'b0);
    end
    applyStep(1'b0, 1'b1, 7'b0010000);
    for (int i = 0; i < 14; i++) begin
      applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL resetmid_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      if (noteStart) sel = noteSel;
      if (noteGate) gateCyc++;
    end
    checks++;
    if (sel !== 3'd4 || gateCyc != S) begin
      failures++; $display("[TB] FAIL resetmid_replay got=%0d/%0d want=4/%0d", sel, gateCyc, S);
    end
  endtask

`ifndef STRUM_QUEUE_EN
  task automatic test_preempt();
    int gc = 0, run = 1;
    bit ended = 1'b0;
    applyStep(1'b0, 1'b1, 7'b0000010);
    for (int i = 0; i < 10 && gc < 4; i++) begin
      applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL preempt_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      if (noteGate) gc++;
    end
    checks++;
    if (gc != 4) begin failures++; $display("[TB] FAIL preempt_reach got=%0d want=4", gc); end
    applyStep(1'b0, 1'b1, 7'b0100000);
    applyStep(1'b0, 1'b0, randSw());
    checks++;
    if ({noteSel, noteStart, noteGate} !== {3'd5, 1'b1, 1'b1}) begin
      failures++; $display("[TB] FAIL preempt_load got=%b want=%b", {noteSel, noteStart, noteGate}, {3'd5, 1'b1, 1'b1});
    end
    for (int i = 0; i < 12; i++) begin
      applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL preempt_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      if (noteGate && !ended) run++;
      else ended = 1'b1;
    end
    checks++;
    if (run != S) begin failures++; $display("[TB] FAIL preempt_sustain got=%0d want=%0d", run, S); end
  endtask
`else
  task automatic test_queue_burst();
    int seq[$];
    int gateCyc = 0;
    bit qfSeen = 1'b0;
    applyStep(1'b1, 1'b0, 7'b0);
    for (int i = 0; i < 76; i++) begin
      if (i < 6) applyStep(1'b0, 1'b1, 7'(1 << i));
      else applyStep(1'b0, 1'b0, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL burst_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
      if (noteStart) seq.push_back(int'(noteSel));
      if (noteGate) gateCyc++;
      if (queueFull) qfSeen = 1'b1;
    end
    checks++;
    if (seq.size() != 5) begin
      failures++; $display("[TB] FAIL burst_count got=%0d want=5", seq.size());
    end
    for (int k = 0; k < seq.size() && k < 5; k++) begin
      checks++;
      if (seq[k] != k) begin failures++; $display("[TB] FAIL burst_order idx=%0d got=%0d want=%0d", k, seq[k], k); end
    end
    checks++;
    if (dropCount !== 8'd1) begin failures++; $display("[TB] FAIL burst_drop got=%0d want=1", dropCount); end
    checks++;
    if (!qfSeen) begin failures++; $display("[TB] FAIL burst_full got=0 want=1"); end
    checks++;
    if (gateCyc != 5 * S) begin failures++; $display("[TB] FAIL burst_gate got=%0d want=%0d", gateCyc, 5 * S); end
  endtask

  task automatic test_drop_saturation();
    applyStep(1'b1, 1'b0, 7'b0);
    for (int i = 0; i < 340; i++) begin
      applyStep(1'b0, 1'b1, randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL sat_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
    end
    checks++;
    if ({queueFull, dropCount} !== {1'b1, 8'd255}) begin
      failures++; $display("[TB] FAIL sat_value got=%0d/%0d want=1/255", queueFull, dropCount);
    end
  endtask
`endif

  task automatic test_random();
    logic rst;
    applyStep(1'b1, 1'b0, 7'b0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      applyStep(rst, ($urandom_range(0, 5) == 0), randSw());
      checks++;
      if (obs !== expVec()) begin
        failures++; $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", cyc, obs, expVec());
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    strumEdge = 1'b0;
    switches  = 7'b0;
    test_reset();
    test_single_strum();
    test_invalid_selection();
    test_reset_mid_note();
`ifndef STRUM_QUEUE_EN
    test_preempt();
`else
    test_queue_burst();
    test_drop_saturation();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sequences strum events into timed note playback for the tone generator. It captures the fret switches on each debounced strum edge, encodes the selection into a 3-bit note code, and drives note select plus a gate for a fixed sustain time. A fixed silent gap follows each note. It sits between the input conditioner (strum edges) and the frequency generator (note select), replacing the free-running latch on the note select.

## Interface
Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz
- SUSTAIN_MS, 500, note duration in milliseconds; SUSTAIN_CYCLES = CLK_HZ/1000*SUSTAIN_MS, must be ≥ 2
- GAP_CYCLES, 1024, silent cycles between consecutive notes, must be ≥ 1
- QUEUE_DEPTH, 4, strum queue entries, power of two, only used with the queue feature

Ports:
- clk  in  1  system clock, all logic on its rising edge
- reset  in  1  synchronous, active-high
- strumEdge  in  1  single-cycle pulse, the OR of the conditioner's positive and negative edges
- switches  in  7  fret switches; bit i one-hot selects note code i
- noteSel  out  3  note code to the frequency generator (A=0 … G=6)
- noteGate  out  1  high while a note sounds
- noteStart  out  1  one-cycle pulse in the first cycle of each note
- busy  out  1  high in every state other than IDLE
- queueFull  out  1  strum queue full; tied 0 without the queue feature
- dropCount  out  8  strums dropped because the queue was full; saturates at 255; tied 0 without the queue feature

## Operation
- **Encoding** at strumEdge: exactly one bit i of switches set → code i. Zero bits or more than one bit set → code 6 (G).
- **FSM states:** IDLE, PLAY, GAP.
  - IDLE: if a note is pending, load it and go to PLAY.
  - PLAY: noteGate=1 and the sustain counter decrements. When the counter reaches 0, go to GAP.
  - GAP: noteGate=0 for GAP_CYCLES. Then, if a note is pending, load it directly and go to PLAY; otherwise go to IDLE.
- **Load:** noteSel takes the note code, noteStart pulses for one cycle, and the sustain counter is set to SUSTAIN_CYCLES-1.
- **Hold:** noteSel keeps the last played code through GAP and IDLE; it changes only at a load.
- **Counter widths:** sustain counter is $clog2(SUSTAIN_CYCLES) bits; gap counter is $clog2(GAP_CYCLES+1) bits. There is no wrap: counters stop at 0.
- **Reset** (also mid-note): state IDLE, noteSel=0, noteGate=0, noteStart=0, busy=0, queueFull=0, dropCount=0, queue emptied. Each output takes its reset value on the clock edge where reset is sampled high. Any strumEdge in the same cycle as reset is ignored.

## Timing
- noteGate is high for exactly SUSTAIN_CYCLES cycles per note.
- Between back-to-back notes, noteGate is low for exactly GAP_CYCLES cycles.
- With the queue feature, from IDLE with an empty queue: strumEdge sampled at edge n → noteSel, noteGate and noteStart valid after edge n+2.
- Without the queue feature, from any state: strumEdge sampled at edge n → new note loaded, outputs valid after edge n+1.
- strumEdge on consecutive cycles counts as separate strums.

## Configuration
- Macro: STRUM_QUEUE_EN.
- **Defined:** strums are pushed into a FIFO of QUEUE_DEPTH entries and played in order; none is preempted.
  - A push while full is dropped, and dropCount increments, saturating at 255.
  - Simultaneous push and pop while full: the pop frees a slot and the push is accepted, with no drop.
  - queueFull reflects the registered occupancy.
- **Undefined:** there is no queue. A strumEdge in any state preempts the current note, loads the new code, restarts the sustain and enters PLAY. Any GAP in progress is abandoned. queueFull and dropCount are constant 0.

## Structure
- Package note_pkg holds:
  - note code constants A..G (3'd0..3'd6)
  - NOTE_W = 3
  - DEFAULT_NOTE = G
  - the FSM state enum
- Sub-module note_queue: a synchronous FIFO with push/pop/full/empty ports, instantiated only under STRUM_QUEUE_EN.
- The frequency generator is unchanged; its note select input is driven from noteSel.

## Test plan
Bench parameters: CLK_HZ=4000, SUSTAIN_MS=2 (8 cycles), GAP_CYCLES=2, QUEUE_DEPTH=4.
- **Single strum:** switches=7'b0001000, one strumEdge → noteSel=3, noteStart pulses once, noteGate high 8 cycles, then busy drops after 2 gap cycles.
- **Invalid selection:** switches=7'b0000000, then 7'b0110000, each strummed → both play noteSel=6.
- **Queued burst (STRUM_QUEUE_EN):** 6 strums on consecutive cycles with codes 0..5 → the first is loaded immediately and 4 are queued. The last is dropped, so codes 0,1,2,3,4 play in order, each 8 cycles with 2-cycle gaps, dropCount=1, and queueFull is high while 4 entries are queued.
- **Preempt (macro undefined):** strum code 1, then strum code 5 at gate cycle 4 → noteSel=5 one cycle later, noteStart pulses, and noteGate stays high 8 more cycles with no gap.
- **Reset mid-note:** assert reset at gate cycle 3 → after that edge noteGate=0, busy=0, noteSel=0, dropCount=0. A strum after reset plays normally.
- **dropCount saturation:** hold the queue full and push 300 extra strums → dropCount=255.
